// File: rtl/seq_detect_param.sv
// Serial detector for a run-time loadable LEN-bit pattern with overlap/non-overlap modes; out pulses 1 cycle after the final bit.
// The en input stalls the stream, and a pattern load restarts the search.
module seq_detect_param #(
  parameter int              LEN         = 4,
  parameter logic [LEN-1:0]  RST_PATTERN = 4'b1011,
  parameter int              CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             signal,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [LEN-1:0]   pat_in,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(LEN);

  logic [LEN-1:0] pattern;
  logic [LEN-1:0] hist;
  logic [LEN-1:0] hist_n;
  logic [FW-1:0]  fill;
  logic [FW-1:0]  fill_n;
  logic           match;

  always_comb begin
    hist_n = {hist[LEN-2:0], signal};
    fill_n = (fill == FULL) ? fill : fill + 1'b1;
    match  = en && !pat_load && (fill_n == FULL) && (hist_n == pattern);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern <= RST_PATTERN;
      hist    <= '0;
      fill    <= '0;
      out     <= 1'b0;
    end else if (pat_load) begin
      pattern <= pat_in;
      hist    <= '0;
      fill    <= '0;
      out     <= 1'b0;
    end else if (en) begin
      hist <= hist_n;
      // Non-overlap mode forces a full window of fresh bits after a hit
      fill <= (match && !overlap) ? '0 : fill_n;
      out  <= match;
    end else begin
      out <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
    end else if (clr_cnt) begin
      match_cnt <= '0;
    end else if (match && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule
